// File: rtl/ksa_pkg.sv
// Shared constants and state type for the key-search datapath.
package ksa_pkg;

  localparam logic [7:0] CHAR_LO_A  = 8'h61;
  localparam logic [7:0] CHAR_LO_Z  = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam int MSG_LEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_RUN
  } chk_state_t;

endpackage

// File: rtl/is_msg_char.sv
// Combinational classifier: a message byte is legal if it is 'a'..'z' or a space.
module is_msg_char
  import ksa_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       valid_o
);

  assign valid_o = (char_i == CHAR_SPACE) ||
                   ((char_i >= CHAR_LO_A) && (char_i <= CHAR_LO_Z));

endmodule

// File: rtl/message_checker.sv
// Streams MSG_LEN bytes out of the decrypted-message RAM and checks each one,
// stopping at the first illegal byte.
module message_checker
  import ksa_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT,
  parameter int D_BASE  = 0,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] d_q,
  output logic [ADDR_W-1:0] d_address,
  output logic              d_wren,
  output logic              finish,
  output logic              msg_ok,
  output logic [ADDR_W-1:0] bad_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  localparam int                CNT_W     = $clog2(MSG_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MSG_LEN);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(D_BASE);

  chk_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              p_vld_q, p_vld_d;
  logic [ADDR_W-1:0] p_idx_q, p_idx_d;
  logic              start_prev_q;
  logic              finish_q, finish_d;
  logic              msg_ok_q, msg_ok_d;
  logic [ADDR_W-1:0] bad_addr_q, bad_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic char_ok;
  logic byte_bad;

  is_msg_char u_is_msg_char (
    .char_i  (d_q[7:0]),
    .valid_o (char_ok)
  );

  // q belongs to the address issued last cycle; p_vld says whether that issue happened.
  assign byte_bad = p_vld_q && !char_ok;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    p_vld_d     = p_vld_q;
    p_idx_d     = p_idx_q;
    finish_d    = 1'b0;
    msg_ok_d    = msg_ok_q;
    bad_addr_d  = bad_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    case (state_q)
      CHK_IDLE: begin
        p_vld_d = 1'b0;
        if (start && !start_prev_q) begin
          state_d    = CHK_RUN;
          addr_d     = BASE_ADDR;
          cnt_d      = '0;
          msg_ok_d   = 1'b0;
          bad_addr_d = '0;
        end
      end

      CHK_RUN: begin
        if ((cnt_q < CNT_MAX) && !byte_bad) begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q + CNT_W'(1);
          p_vld_d = 1'b1;
          p_idx_d = addr_q;
        end else begin
          p_vld_d = 1'b0;
        end

        if (p_vld_q) begin
          out_data_d = d_q;
          if (char_ok) begin
            out_valid_d = 1'b1;
            // Only the last byte is evaluated once every address has been issued.
            if (cnt_q == CNT_MAX) begin
              msg_ok_d = 1'b1;
              finish_d = 1'b1;
              state_d  = CHK_IDLE;
            end
          end else begin
            bad_addr_d = p_idx_q;
            msg_ok_d   = 1'b0;
            finish_d   = 1'b1;
            state_d    = CHK_IDLE;
          end
        end
      end

      default: begin
        state_d = CHK_IDLE;
        p_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CHK_IDLE;
      addr_q       <= BASE_ADDR;
      cnt_q        <= '0;
      p_vld_q      <= 1'b0;
      p_idx_q      <= '0;
      start_prev_q <= 1'b0;
      finish_q     <= 1'b0;
      msg_ok_q     <= 1'b0;
      bad_addr_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      p_vld_q      <= p_vld_d;
      p_idx_q      <= p_idx_d;
      start_prev_q <= start;
      finish_q     <= finish_d;
      msg_ok_q     <= msg_ok_d;
      bad_addr_q   <= bad_addr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign d_address = addr_q;
  assign d_wren    = 1'b0;
  assign finish    = finish_q;
  assign msg_ok    = msg_ok_q;
  assign bad_addr  = bad_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_message_checker.sv
// Bench for message_checker: RAM model, directed and random messages, scoreboard of expected bytes.
module tb_message_checker;

  localparam int MSG_LEN = 32;
  localparam int D_BASE  = 0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] d_q;
  logic [7:0] d_address;
  logic       d_wren;
  logic       finish;
  logic       msg_ok;
  logic [7:0] bad_addr;
  logic [7:0] out_data;
  logic       out_valid;

  logic [7:0] mem [256];
  logic [7:0] ram_addr_q = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  message_checker #(
    .MSG_LEN (MSG_LEN),
    .D_BASE  (D_BASE),
    .ADDR_W  (8),
    .DATA_W  (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .d_q       (d_q),
    .d_address (d_address),
    .d_wren    (d_wren),
    .finish    (finish),
    .msg_ok    (msg_ok),
    .bad_addr  (bad_addr),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  // clock / RAM model (registered address, unregistered q)
  always #5 clk = ~clk;
  always @(posedge clk) ram_addr_q <= d_address;
  assign d_q = mem[ram_addr_q];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_char_ok(input logic [7:0] b);
    string legal;
    legal = "abcdefghijklmnopqrstuvwxyz ";
    for (int i = 0; i < legal.len(); i++)
      if (legal[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] rand_legal();
    int r;
    r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  task automatic fill_all(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  // One complete launch + observation, checked against the message contents.
  task automatic run_one(input string name);
    int k, fe, lim, exp_strobes, n_strobes, n_fin, fin_edge;
    logic [7:0] b;
    k = -1; n_strobes = 0; n_fin = 0; fin_edge = -1;
    exp_q.delete();
    for (int i = 0; i < MSG_LEN; i++) begin
      b = mem[(D_BASE + i) % 256];
      if (!model_char_ok(b)) begin
        k = i;
        break;
      end
      exp_q.push_back(b);
    end
    fe  = (k < 0) ? MSG_LEN + 1 : k + 2;
    lim = (k < 0) ? MSG_LEN : k + 1;
    exp_strobes = exp_q.size();

    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    check_eq({name, " launch msg_ok"}, 32'(msg_ok), 32'd0);
    check_eq({name, " launch finish"}, 32'(finish), 32'd0);
    check_eq({name, " launch addr"}, 32'(d_address), 32'(D_BASE % 256));

    for (int e = 1; e <= fe + 3; e++) begin
      @(posedge clk); #1;
      check_eq({name, " addr"}, 32'(d_address), 32'((D_BASE + ((e < lim) ? e : lim)) % 256));
      if (out_valid) begin
        n_strobes++;
        if (exp_q.size() > 0) check_eq({name, " out_data"}, 32'(out_data), 32'(exp_q.pop_front()));
      end
      if (finish) begin
        n_fin++;
        fin_edge = e;
      end
    end

    check_eq({name, " finish pulses"}, 32'(n_fin), 32'd1);
    check_eq({name, " finish edge"}, 32'(fin_edge), 32'(fe));
    check_eq({name, " strobes"}, 32'(n_strobes), 32'(exp_strobes));
    check_eq({name, " msg_ok"}, 32'(msg_ok), (k < 0) ? 32'd1 : 32'd0);
    check_eq({name, " bad_addr"}, 32'(bad_addr), (k < 0) ? 32'd0 : 32'((D_BASE + k) % 256));
  endtask

  initial begin
    int extra;
    logic [7:0] bvals [6];
    bvals[0] = 8'h20; bvals[1] = 8'h61; bvals[2] = 8'h7A;
    bvals[3] = 8'h60; bvals[4] = 8'h7B; bvals[5] = 8'h1F;

    fill_all(8'h61);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset addr", 32'(d_address), 32'(D_BASE));
    check_eq("reset finish", 32'(finish), 32'd0);
    check_eq("reset msg_ok", 32'(msg_ok), 32'd0);
    check_eq("reset bad_addr", 32'(bad_addr), 32'd0);
    check_eq("reset out_data", 32'(out_data), 32'd0);
    check_eq("reset out_valid", 32'(out_valid), 32'd0);
    check_eq("wren", 32'(d_wren), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 256; i++) mem[i] = (i < 26) ? 8'(8'h61 + i) : 8'h20;
    run_one("alpha");

    extra = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (finish) extra++;
    end
    check_eq("held start finishes", 32'(extra), 32'd0);
    check_eq("held start addr", 32'(d_address), 32'(D_BASE + MSG_LEN));

    run_one("relaunch");

    fill_all(8'h61);
    mem[5] = 8'h41;
    run_one("bad5");

    for (int j = 0; j < 6; j++) begin
      fill_all(8'h61);
      mem[D_BASE] = bvals[j];
      run_one($sformatf("edge%0h", bvals[j]));
    end

    fill_all(8'h61);
    mem[D_BASE + MSG_LEN - 1] = 8'h00;
    run_one("last0");

    // reset dropped in the middle of a run
    fill_all(8'h62);
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #2 reset_n = 1'b0;
    start = 1'b0;
    #1;
    check_eq("midreset addr", 32'(d_address), 32'(D_BASE));
    check_eq("midreset out_valid", 32'(out_valid), 32'd0);
    check_eq("midreset out_data", 32'(out_data), 32'd0);
    check_eq("midreset msg_ok", 32'(msg_ok), 32'd0);
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (finish) extra++;
    end
    check_eq("midreset finishes", 32'(extra), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    run_one("after_reset");

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = rand_legal();
      if ($urandom_range(0, 1) == 1)
        mem[(D_BASE + $urandom_range(0, MSG_LEN - 1)) % 256] = 8'($urandom_range(0, 255));
      run_one($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
